product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//   Downstream stage of CommonMultiplier: consumes its 2*DATA_WIDTH-bit products over a
//   valid/ready handshake and sums each group of ACC_COUNT consecutive products.
//   Emits one registered sum per group. Forms the accumulate half of a MAC datapath.
// PARAMETERS
//   DATA_WIDTH  4   multiplier operand width; product input is 2*DATA_WIDTH bits
//   ACC_COUNT   4   products per group, >=2
//   ACC_WIDTH   10  accumulator/result width, >=2*DATA_WIDTH
// PORTS
//   clock         in   1             single clock, rising edge
//   reset         in   1             asynchronous, active-high
//   productValue  in   2*DATA_WIDTH  product from CommonMultiplier outputValue
//   inputValid    in   1             productValue valid
//   inputReady    out  1             block can accept a product
//   clearAccum    in   1             synchronous abort of the partial group
//   outputValue   out  ACC_WIDTH     group sum
//   outputValid   out  1             outputValue valid
//   outputReady   in   1             consumer accepts outputValue
// BEHAVIOUR
//   - Reset (async assert): state=ACCUM, sum=0, count=0, outputValue=0, outputValid=0.
//   - States: ACCUM (collecting), HOLD (result presented). inputReady = (state==ACCUM).
//   - Accept = inputValid & inputReady. Product zero-extended to ACC_WIDTH before add.
//   - ACCUM, accept, count<ACC_COUNT-1: sum+=product, count++.
//   - ACCUM, accept, count==ACC_COUNT-1: outputValue<=sum+product, outputValid<=1,
//     sum<=0, count<=0, ->HOLD. Latency: result valid 1 cycle after last accept.
//   - HOLD: outputValue/outputValid stable until outputReady=1; that edge:
//     outputValid<=0, ->ACCUM. inputReady=0 throughout HOLD; inputValid ignored.
//   - No same-cycle bypass: earliest next accept is the cycle after output handshake.
//   - clearAccum in ACCUM: sum<=0, count<=0. clearAccum with simultaneous accept:
//     clear wins over old partial; accepted product starts new group (sum=product,
//     count=1). clearAccum in HOLD: ignored, held result kept.
//   - Arithmetic unsigned; without overflow handling, sum wraps modulo 2**ACC_WIDTH.
//   - Reset mid-group or mid-HOLD: partial sum and held result discarded.
//   - inputValid low between accepts: count/sum hold (gaps allowed).
// CONFIGURATION
//   ACC_SATURATE_EN defined: any add exceeding 2**ACC_WIDTH-1 clamps to
//     2**ACC_WIDTH-1; further adds within the group keep it clamped.
//   ACC_SATURATE_EN undefined: modulo wrap-around; no clamping logic synthesised.
// TESTING
//   1 Reset mid-group: accept 7,9 then pulse reset -> outputValid=0; then 1,2,3,4
//     -> outputValue=10, outputValid=1 one cycle after 4th accept.
//   2 Max products: 225 x4, ACC_WIDTH=10 -> outputValue=900, no wrap.
//   3 Backpressure: outputReady=0 for 5 cycles with inputValid=1 -> outputValid and
//     value stable, inputReady=0, no products absorbed; outputReady=1 -> ACCUM next cycle.
//   4 Clear+accept: accept 5,6; then clearAccum=1 with product 7; then 1,1,1
//     -> outputValue=10.
//   5 Overflow ACC_WIDTH=8, 225 x4: with ACC_SATURATE_EN -> 255; without -> 132.
//   6 Chained with CommonMultiplier (DATA_WIDTH=4): sweep all i*j pairs, groups of 4,
//     random inputValid gaps and outputReady stalls -> every sum equals model, none lost.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator
//   Accumulate half of a MAC datapath. It takes 2*DATA_WIDTH-bit products over a
//   valid/ready handshake, adds up each group of ACC_COUNT consecutive products,
//   and presents one registered sum per group.
//
//   Optional feature macro: ACC_SATURATE_EN
//     defined   -> any add that overflows ACC_WIDTH clamps to all-ones
//     undefined -> sums wrap modulo 2**ACC_WIDTH
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   productValue  in   product from the multiplier
//   inputValid    in   productValue is valid
//   inputReady    out  block can accept a product (high while collecting)
//   clearAccum    in   synchronous abort of the partial group
//   outputValue   out  group sum
//   outputValid   out  outputValue is valid
//   outputReady   in   consumer accepts outputValue
module product_accumulator #(
   parameter int DATA_WIDTH = 4,
   parameter int ACC_COUNT  = 4,
   parameter int ACC_WIDTH  = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [2*DATA_WIDTH-1:0] productValue,
   input  logic                    inputValid,
   output logic                    inputReady,
   input  logic                    clearAccum,
   output logic [ACC_WIDTH-1:0]    outputValue,
   output logic                    outputValid,
   input  logic                    outputReady
);

   localparam int CNT_W = (ACC_COUNT > 2) ? $clog2(ACC_COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_COUNT - 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t               state;
   logic [ACC_WIDTH-1:0] sum;
   logic [CNT_W-1:0]     count;
   logic [ACC_WIDTH-1:0] product_ext;
   logic [ACC_WIDTH-1:0] next_sum;
   logic                 accept;

   assign product_ext = ACC_WIDTH'(productValue);
   assign inputReady  = (state == ACCUM);
   assign accept      = inputValid & inputReady;

`ifdef ACC_SATURATE_EN
   // One extra bit catches the carry out. Once clamped, the sum stays clamped
   // because any further non-zero add carries out again.
   logic [ACC_WIDTH:0] wide_sum;
   assign wide_sum = {1'b0, sum} + {1'b0, product_ext};
   assign next_sum = wide_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : wide_sum[ACC_WIDTH-1:0];
`else
   assign next_sum = sum + product_ext;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ACCUM;
         sum         <= '0;
         count       <= '0;
         outputValue <= '0;
         outputValid <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (clearAccum) begin
                  // Clear discards the old partial sum. A product accepted in the
                  // same cycle becomes the first element of a fresh group.
                  if (accept) begin
                     sum   <= product_ext;
                     count <= CNT_W'(1);
                  end else begin
                     sum   <= '0;
                     count <= '0;
                  end
               end else if (accept) begin
                  if (count == LAST) begin
                     outputValue <= next_sum;
                     outputValid <= 1'b1;
                     sum         <= '0;
                     count       <= '0;
                     state       <= HOLD;
                  end else begin
                     sum   <= next_sum;
                     count <= count + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               // Result is held until the consumer takes it. Inputs and clear
               // are ignored here, and the next accept is possible only after
               // the state returns to ACCUM.
               if (outputReady) begin
                  outputValid <= 1'b0;
                  state       <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] productValue = '0;
   logic       inputValid = 1'b0, clearAccum = 1'b0, outputReady = 1'b0;
   logic       inputReady, outputValid;
   logic [9:0] outputValue;

   // Narrow instance for the overflow check (ACC_WIDTH=8)
   logic [7:0] p8 = '0;
   logic       v8 = 1'b0, c8 = 1'b0, r8 = 1'b0;
   logic       ir8, ov8;
   logic [7:0] val8;

   always #5 clock = ~clock;

   product_accumulator #(.DATA_WIDTH(4), .ACC_COUNT(4), .ACC_WIDTH(10)) dut (
      .clock(clock), .reset(reset), .productValue(productValue), .inputValid(inputValid),
      .inputReady(inputReady), .clearAccum(clearAccum), .outputValue(outputValue),
      .outputValid(outputValid), .outputReady(outputReady));

   product_accumulator #(.DATA_WIDTH(4), .ACC_COUNT(4), .ACC_WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .productValue(p8), .inputValid(v8),
      .inputReady(ir8), .clearAccum(c8), .outputValue(val8),
      .outputValid(ov8), .outputReady(r8));

   typedef struct {
      logic [7:0] prod;
      logic       vld, clr, rdy;
      logic       e_ovld;
      logic [9:0] e_val;
      logic       e_irdy;
   } vec_t;

   vec_t tbl[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input int prod, input bit vld, input bit clr, input bit rdy,
                      input bit eov, input int ev, input bit eir);
      vec_t v;
      v.prod = 8'(prod); v.vld = vld; v.clr = clr; v.rdy = rdy;
      v.e_ovld = eov; v.e_val = 10'(ev); v.e_irdy = eir;
      tbl.push_back(v);
   endtask

   task automatic feed(input int prod);
      productValue = 8'(prod); inputValid = 1'b1;
      step();
   endtask

   int exp_s[64];
   int pi, oi, s;
   bit v, r, acc_now;

   initial begin
      // ---------------- reset state
      step(); step();
      chk("rst_ovld", outputValid, 0);
      chk("rst_val", outputValue, 0);
      chk("rst_irdy", inputReady, 1);
      chk("rst8_ovld", ov8, 0);
      reset = 1'b0;
      step();

      // ---------------- reset mid-group
      feed(7); feed(9);
      inputValid = 1'b0;
      reset = 1'b1;
      #1;
      chk("midrst_ovld", outputValid, 0);
      chk("midrst_irdy", inputReady, 1);
      step();
      reset = 1'b0;
      step();
      feed(1); feed(2); feed(3);
      chk("midrst_early", outputValid, 0);
      feed(4);
      inputValid = 1'b0;
      chk("midrst_ovld4", outputValid, 1);
      chk("midrst_val", outputValue, 10);
      outputReady = 1'b1;
      step();
      outputReady = 1'b0;
      chk("midrst_drain", outputValid, 0);

      // ---------------- per-cycle table
      add(1,1,0,0, 0,0,1);   add(2,1,0,0, 0,0,1);   add(3,1,0,0, 0,0,1);
      add(4,1,0,0, 1,10,0);  add(9,1,0,0, 1,10,0);  add(9,1,1,0, 1,10,0);
      add(0,0,0,1, 0,0,1);
      // max products with gaps
      add(225,1,0,0, 0,0,1); add(0,0,0,0, 0,0,1);   add(225,1,0,0, 0,0,1);
      add(0,0,0,0, 0,0,1);   add(225,1,0,0, 0,0,1); add(225,1,0,0, 1,900,0);
      add(0,0,0,1, 0,0,1);
      // clear with simultaneous accept
      add(5,1,0,0, 0,0,1);   add(6,1,0,0, 0,0,1);   add(7,1,1,0, 0,0,1);
      add(1,1,0,0, 0,0,1);   add(1,1,0,0, 0,0,1);   add(1,1,0,0, 1,10,0);
      add(0,0,0,1, 0,0,1);
      // clear alone
      add(50,1,0,0, 0,0,1);  add(0,0,1,0, 0,0,1);   add(1,1,0,0, 0,0,1);
      add(2,1,0,0, 0,0,1);   add(3,1,0,0, 0,0,1);   add(4,1,0,0, 1,10,0);
      // handshake cycle with a product offered: product must not be taken
      add(100,1,0,1, 0,0,1);
      add(1,1,0,0, 0,0,1);   add(1,1,0,0, 0,0,1);   add(1,1,0,0, 0,0,1);
      add(1,1,0,0, 1,4,0);   add(0,0,0,1, 0,0,1);
      // clear+accept on what would have been the last product
      add(1,1,0,0, 0,0,1);   add(1,1,0,0, 0,0,1);   add(1,1,0,0, 0,0,1);
      add(8,1,1,0, 0,0,1);   add(1,1,0,0, 0,0,1);   add(1,1,0,0, 0,0,1);
      add(1,1,0,0, 1,11,0);  add(0,0,0,1, 0,0,1);

      for (int i = 0; i < tbl.size(); i++) begin
         productValue = tbl[i].prod; inputValid = tbl[i].vld;
         clearAccum = tbl[i].clr; outputReady = tbl[i].rdy;
         step();
         chk($sformatf("tbl%0d_ovld", i), outputValid, tbl[i].e_ovld);
         chk($sformatf("tbl%0d_irdy", i), inputReady, tbl[i].e_irdy);
         if (tbl[i].e_ovld) chk($sformatf("tbl%0d_val", i), outputValue, tbl[i].e_val);
      end
      inputValid = 1'b0; clearAccum = 1'b0; outputReady = 1'b0;

      // ---------------- backpressure
      feed(10); feed(20); feed(30); feed(40);
      productValue = 8'd99; inputValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_ovld", outputValid, 1);
         chk("bp_val", outputValue, 100);
         chk("bp_irdy", inputReady, 0);
      end
      inputValid = 1'b0; outputReady = 1'b1;
      step();
      outputReady = 1'b0;
      chk("bp_release_ovld", outputValid, 0);
      chk("bp_release_irdy", inputReady, 1);
      feed(1); feed(1); feed(1); feed(1);
      inputValid = 1'b0;
      chk("bp_after_val", outputValue, 4);
      chk("bp_after_ovld", outputValid, 1);
      outputReady = 1'b1;
      step();
      outputReady = 1'b0;

      // ---------------- overflow at ACC_WIDTH=8
      p8 = 8'd225; v8 = 1'b1;
      for (int i = 0; i < 4; i++) step();
      v8 = 1'b0;
      chk("ovf_ovld", ov8, 1);
`ifdef ACC_SATURATE_EN
      chk("ovf_val", val8, 255);
`else
      chk("ovf_val", val8, 132);
`endif
      r8 = 1'b1;
      step();
      r8 = 1'b0;
      chk("ovf_drain", ov8, 0);

      // ---------------- chained sweep of all i*j with random gaps and stalls
      for (int k = 0; k < 64; k++) begin
         s = 0;
         for (int p = 4*k; p < 4*k + 4; p++) s += (p / 16) * (p % 16);
         exp_s[k] = s % 1024;
      end
      pi = 0; oi = 0;
      for (int cyc = 0; cyc < 6000 && oi < 64; cyc++) begin
         v = (pi < 256) && ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         productValue = 8'((pi / 16) * (pi % 16));
         inputValid = v; outputReady = r;
         acc_now = v && inputReady;
         if (outputValid && r) begin
            chk($sformatf("chain_sum%0d", oi), outputValue, exp_s[oi]);
            oi++;
         end
         step();
         if (acc_now) pi++;
      end
      inputValid = 1'b0; outputReady = 1'b0;
      chk("chain_groups", oi, 64);
      chk("chain_accepts", pi, 256);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
